// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for clk_edge_stopwatch
// Contents: state enum, BCD digit limit, digit geometry.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_e;

   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam int         DIGIT_W    = 4;
   localparam int         NUM_DIGITS = 4;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - synchronizer plus registered rising-edge detector
// Ports:
//   clk_in : system clock
//   rst    : synchronous active-high reset
//   d      : asynchronous input level
//   rise   : one-cycle pulse, SYNC_STAGES+1 cycles after a 0->1 on d
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         prev_q <= sync_q[SYNC_STAGES-1];
         // Registering the detector keeps the pulse glitch-free for the counter
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/clk_edge_stopwatch.sv
// rtl/clk_edge_stopwatch.sv - 4-digit BCD stopwatch timed by edges of clk_N
// Optional feature macro: STOPWATCH_LAP_EN (clear in RUN freezes/releases a lap display)
// Ports:
//   clk_in     : system clock, everything is clocked here
//   rst        : synchronous active-high reset
//   clk_N      : slow divided clock, sampled as asynchronous data
//   start_stop : pulse, toggles run/pause
//   clear      : pulse, zeroes count in PAUSE (lap toggle in RUN when enabled)
//   digits     : {sec_tens, sec_ones, cs_tens, cs_ones} BCD
//   running    : high while in RUN
//   step       : pulse on each centisecond increment
//   wrap       : pulse when 99.99 rolls to 00.00
module clk_edge_stopwatch
   import stopwatch_pkg::*;
#(
   parameter int EDGES_PER_STEP = 50,
   parameter int SYNC_STAGES    = 2
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        clk_N,
   input  logic        start_stop,
   input  logic        clear,
   output logic [15:0] digits,
   output logic        running,
   output logic        step,
   output logic        wrap
);

   localparam int CNT_W = (EDGES_PER_STEP > 1) ? $clog2(EDGES_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EDGES_PER_STEP - 1);

   sw_state_e state_q, state_d;
   logic [CNT_W-1:0]                      cnt_q;
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    live_q;
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    live_nxt;
   logic                                  carry_out;
   logic                                  step_q, wrap_q, running_q;
   logic                                  edge_w;
   logic                                  count_en, step_hit, clear_now;

   edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_edge_sync (
      .clk_in(clk_in),
      .rst   (rst),
      .d     (clk_N),
      .rise  (edge_w)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_stop) state_d = RUN;
         RUN:     if (start_stop) state_d = PAUSE;
         PAUSE:   if (start_stop) state_d = RUN;
                  else if (clear) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // An edge coinciding with the start_stop that leaves RUN is dropped
   assign count_en  = (state_q == RUN) && !start_stop && edge_w;
   assign step_hit  = count_en && (cnt_q == CNT_LAST);
   assign clear_now = (state_q == PAUSE) && (state_d == IDLE);

   // Ripple BCD increment; >= keeps any stray non-BCD code from persisting
   always_comb begin
      logic carry;
      carry    = 1'b1;
      live_nxt = live_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (live_q[i] >= BCD_MAX) begin
               live_nxt[i] = '0;
            end else begin
               live_nxt[i] = live_q[i] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      carry_out = carry;
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         live_q    <= '0;
         step_q    <= 1'b0;
         wrap_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= (state_d == RUN);
         step_q    <= step_hit;
         wrap_q    <= step_hit && carry_out;
         if (clear_now) begin
            cnt_q  <= '0;
            live_q <= '0;
         end else if (count_en) begin
            if (cnt_q == CNT_LAST) begin
               cnt_q  <= '0;
               live_q <= live_nxt;
            end else begin
               cnt_q  <= cnt_q + CNT_W'(1);
            end
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic        lap_act_q;
   logic [15:0] lap_q;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         lap_act_q <= 1'b0;
         lap_q     <= '0;
      end else if ((state_q == RUN) && clear && !start_stop) begin
         lap_act_q <= ~lap_act_q;
         if (!lap_act_q) lap_q <= live_q;
      end else if (clear_now) begin
         lap_act_q <= 1'b0;
      end
   end

   assign digits = lap_act_q ? lap_q : live_q;
`else
   assign digits = live_q;
`endif

   assign running = running_q;
   assign step    = step_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_clk_edge_stopwatch.sv
// tb/tb_clk_edge_stopwatch.sv - self-checking bench for clk_edge_stopwatch
module tb_clk_edge_stopwatch;

`ifdef STOPWATCH_LAP_EN
   localparam bit LAP = 1'b1;
`else
   localparam bit LAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_N = 1'b0;
   logic        start_stop = 1'b0;
   logic        clear = 1'b0;

   logic [15:0] a_digits, f_digits;
   logic        a_running, f_running, a_step, f_step, a_wrap, f_wrap;

   int n_cmp = 0;
   int n_fail = 0;
   int a_step_cnt = 0;

   always #5 clk = ~clk;

   // Spec-default instance for the 50-edge timing checks
   clk_edge_stopwatch u_dut_a (
      .clk_in(clk), .rst(rst), .clk_N(clk_N), .start_stop(start_stop), .clear(clear),
      .digits(a_digits), .running(a_running), .step(a_step), .wrap(a_wrap)
   );

   // One edge per step so long sequences (full wrap) stay short
   clk_edge_stopwatch #(.EDGES_PER_STEP(1), .SYNC_STAGES(3)) u_dut_f (
      .clk_in(clk), .rst(rst), .clk_N(clk_N), .start_stop(start_stop), .clear(clear),
      .digits(f_digits), .running(f_running), .step(f_step), .wrap(f_wrap)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model for u_dut_f
   typedef enum int {M_IDLE, M_RUN, M_PAUSE} m_state_e;
   m_state_e    m_state = M_IDLE;
   int          m_count = 0;
   bit          m_lap = 1'b0;
   logic [15:0] m_lap_val = '0;
   logic [16:0] sb_q[$];

   function automatic logic [15:0] to_bcd(input int n);
      return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         a_step_cnt = 0;
      end else begin
         if (a_step) a_step_cnt++;
         if (f_wrap && !f_step) chk("wrap_without_step", {31'd0, f_wrap}, 32'd0);
         if (f_step) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected_step", 32'd1, 32'd0);
            end else begin
               logic [16:0] e;
               e = sb_q.pop_front();
               chk("sb_digits", {16'd0, f_digits}, {16'd0, e[15:0]});
               chk("sb_wrap", {31'd0, f_wrap}, {31'd0, e[16]});
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clk_N = 1'b0;
      repeat (3) @(negedge clk);
      m_state = M_IDLE; m_count = 0; m_lap = 1'b0; m_lap_val = '0;
      sb_q.delete();
      chk("rst_a_digits", {16'd0, a_digits}, 32'd0);
      chk("rst_f_digits", {16'd0, f_digits}, 32'd0);
      chk("rst_running", {30'd0, a_running, f_running}, 32'd0);
      chk("rst_step_wrap", {28'd0, a_step, f_step, a_wrap, f_wrap}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse(input logic ss, input logic cl);
      if (!ss && !cl) return;
      @(negedge clk);
      start_stop = ss;
      clear = cl;
      @(negedge clk);
      start_stop = 1'b0;
      clear = 1'b0;
      if (ss) begin
         m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
      end else if (m_state == M_PAUSE) begin
         m_state = M_IDLE; m_count = 0; m_lap = 1'b0;
      end else if (m_state == M_RUN && LAP) begin
         if (!m_lap) m_lap_val = to_bcd(m_count);
         m_lap = !m_lap;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic rises(input int n);
      for (int i = 0; i < n; i++) begin
         clk_N = 1'b1;
         if (m_state == M_RUN) begin
            m_count = (m_count + 1) % 10000;
            sb_q.push_back({(m_count == 0), (m_lap ? m_lap_val : to_bcd(m_count))});
         end
         repeat (2) @(negedge clk);
         clk_N = 1'b0;
         repeat (2) @(negedge clk);
      end
      repeat (8) @(negedge clk);
   endtask

   typedef struct {
      logic        ss;
      logic        cl;
      int          n;
      logic [15:0] exp_d;
      logic        exp_run;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs[NV];

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 123,  16'h0123, 1'b1};
      vecs[1]  = '{1'b1, 1'b0, 200,  16'h0123, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1,    16'h0124, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 0,    16'h0124, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 5,    16'h0000, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 7,    16'h0007, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, 0,    16'h0007, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 0,    16'h0007, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 3,    (LAP ? 16'h0007 : 16'h0010), 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 0,    16'h0010, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 0,    16'h0010, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 0,    16'h0000, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 300,  16'h0300, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 100,  (LAP ? 16'h0300 : 16'h0400), 1'b1};
      vecs[14] = '{1'b0, 1'b1, 0,    16'h0400, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 0,    16'h0400, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 0,    16'h0000, 1'b0};
      vecs[17] = '{1'b1, 1'b0, 9999, 16'h9999, 1'b1};
      vecs[18] = '{1'b0, 1'b0, 1,    16'h0000, 1'b1};

      do_reset();

      // Idle clk_N activity must not count
      rises(50);
      chk("idle_a_digits", {16'd0, a_digits}, 32'd0);
      chk("idle_a_steps", a_step_cnt, 32'd0);
      chk("idle_a_running", {31'd0, a_running}, 32'd0);

      pulse(1'b1, 1'b0);
      rises(50);
      chk("a_one_step_cnt", a_step_cnt, 32'd1);
      chk("a_one_step_digits", {16'd0, a_digits}, 32'h0001);
      chk("a_running", {31'd0, a_running}, 32'd1);
      rises(450);
      chk("a_500_digits", {16'd0, a_digits}, 32'h0010);
      chk("a_500_steps", a_step_cnt, 32'd10);
      chk("sb_drained_a", sb_q.size(), 32'd0);

      do_reset();
      for (int i = 0; i < NV; i++) begin
         pulse(vecs[i].ss, vecs[i].cl);
         rises(vecs[i].n);
         chk($sformatf("vec%0d_digits", i), {16'd0, f_digits}, {16'd0, vecs[i].exp_d});
         chk($sformatf("vec%0d_running", i), {31'd0, f_running}, {31'd0, vecs[i].exp_run});
      end
      chk("sb_drained_f", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
